branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter XLEN, default 64, width of pc, imm and next_pc.
REQ-002 SHALL have parameter CNTW, default 32, width of statistics counters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  upstream presents a compare result.
REQ-006 SHALL have port in_ready  output  1  block can accept an entry.
REQ-007 SHALL have port funct3  input  3  branch condition code.
REQ-008 SHALL have port eq, lt, ltu  input  1 each  EQ/LT/LTu flags from the upstream comparator tree.
REQ-009 SHALL have port pc  input  XLEN  branch instruction address.
REQ-010 SHALL have port imm  input  XLEN  sign-extended branch offset.
REQ-011 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-012 SHALL have port out_valid  output  1  resolved branch available.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-014 SHALL have port taken  output  1  branch condition true.
REQ-015 SHALL have port next_pc  output  XLEN  resolved fetch address.
REQ-016 SHALL have port illegal  output  1  funct3 is 010 or 011.
REQ-017 SHALL have ports br_count, taken_count  output  CNTW each, present only with BRANCH_STATS_EN.

Function
REQ-018 SHALL decode taken: 000 eq; 001 !eq; 100 lt; 101 !lt; 110 ltu; 111 !ltu; 010/011 taken=0, illegal=1.
REQ-019 SHALL compute next_pc = taken ? pc+imm : pc+4, truncated modulo 2^XLEN.
REQ-020 SHALL perform decode and add at input and store {taken, illegal, next_pc} in a 2-entry in-order buffer.
REQ-021 SHALL treat input handshake as in_valid&&in_ready and output handshake as out_valid&&out_ready.
REQ-022 SHALL use occupancy states EMPTY, ONE, FULL: push only -> up one, pop only -> down one, push+pop -> unchanged.
REQ-023 SHALL drive in_ready = (state != FULL), combinationally independent of out_ready.
REQ-024 SHALL drive out_valid = (state != EMPTY); outputs come from the oldest entry.
REQ-025 SHALL give latency of exactly one cycle: entry accepted at edge N is visible on out_valid after edge N when EMPTY.
REQ-026 SHALL hold taken, next_pc and illegal stable while out_valid && !out_ready.
REQ-027 SHALL, in state ONE with simultaneous push and pop, present the new entry after the edge.
REQ-028 SHALL, on flush at an edge, go to EMPTY and ignore any push or pop in that cycle.
REQ-029 SHALL ignore eq/lt/ltu/funct3/pc/imm when no input handshake occurs.

Reset
REQ-030 SHALL, while rst_n is low, force state EMPTY, out_valid=0, taken=0, illegal=0, next_pc=0, counters=0, asynchronously.
REQ-031 SHALL drive in_ready=1 after reset, and discard buffered entries when reset is asserted mid-operation.
REQ-032 SHALL sample no input on the first rising edge coinciding with rst_n deassertion.

Configuration
REQ-033 SHALL, with macro BRANCH_STATS_EN defined, count br_count +1 per output handshake and taken_count +1 per output handshake with taken=1, both saturating at 2^CNTW-1.
REQ-034 SHALL leave flush entries uncounted.
REQ-035 SHALL, without BRANCH_STATS_EN, omit the counters and ports entirely, with all other behaviour identical.

Verification
REQ-036 SHALL test BEQ: funct3=000, eq=1, pc=0x1000, imm=0x20, out_ready=1 -> next cycle out_valid=1, taken=1, next_pc=0x1020.
REQ-037 SHALL test BGEU wrap: funct3=111, ltu=1, pc=0xFFFFFFFFFFFFFFFC -> taken=0, next_pc=0x0.
REQ-038 SHALL test backpressure: out_ready=0, push 3 consecutive -> in_ready=0 after 2 accepted; raise out_ready -> both drain in order, values unchanged while stalled.
REQ-039 SHALL test illegal code: funct3=010 -> illegal=1, taken=0, next_pc=pc+4.
REQ-040 SHALL test flush while FULL together with in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry retained, counters unchanged.
REQ-041 SHALL test async reset asserted mid-cycle while FULL -> out_valid=0 immediately, before any clock edge.

Source files
------------

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
//   Resolves a conditional branch from pre-computed comparator flags. The
//   condition decode and target add happen at the input. Each result is held
//   in a 2-entry in-order buffer and driven through a valid/ready handshake.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready upstream handshake (in_ready = buffer not full)
//   funct3            branch condition code
//   eq, lt, ltu       comparator flags
//   pc, imm           branch address and sign-extended offset
//   flush             synchronous discard of all buffered entries
//   out_valid/out_ready downstream handshake
//   taken, next_pc, illegal  oldest buffered result
//   br_count, taken_count    saturating statistics (only with BRANCH_STATS_EN)
//
// Build option
//   BRANCH_STATS_EN   when defined, adds the two statistics counters and ports.
// -----------------------------------------------------------------------------
module branch_resolve #(
  parameter int XLEN = 64,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            eq,
  input  logic            lt,
  input  logic            ltu,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic [XLEN-1:0] next_pc,
  output logic            illegal
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNTW-1:0] br_count,
  output logic [CNTW-1:0] taken_count
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic            taken;
    logic            illegal;
    logic [XLEN-1:0] next_pc;
  } entry_t;

  function automatic logic cond_taken(input logic [2:0] f3, input logic e,
                                      input logic l, input logic lu);
    logic t;
    t = 1'b0;
    case (f3)
      3'b000:  t = e;
      3'b001:  t = !e;
      3'b100:  t = l;
      3'b101:  t = !l;
      3'b110:  t = lu;
      3'b111:  t = !lu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  state_t state_q, state_d;
  entry_t entry_p0;
  entry_t head_p1, tail_p1;
  logic   push, pop;
  logic   load_head, load_tail, head_from_tail;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // ---- stage p0: condition decode and target add at the input ----
  always_comb begin
    entry_p0.illegal = (funct3[2:1] == 2'b01);
    entry_p0.taken   = cond_taken(funct3, eq, lt, ltu);
    entry_p0.next_pc = entry_p0.taken ? (pc + imm)
                                      : (pc + {{(XLEN-3){1'b0}}, 3'd4});
  end

  // Occupancy FSM. Head is always the oldest entry; a pop from FULL shifts
  // the tail into the head slot.
  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    load_tail      = 1'b0;
    head_from_tail = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          state_d   = ONE;
          load_head = 1'b1;
        end
        ONE: begin
          if (push && pop) begin
            load_head = 1'b1;
          end else if (push) begin
            state_d   = FULL;
            load_tail = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: if (pop) begin
          state_d        = ONE;
          head_from_tail = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // ---- stage p1: two buffered entries ----
  // Data is reset as well because outputs must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_p1 <= '0;
      tail_p1 <= '0;
    end else begin
      if (load_head)           head_p1 <= entry_p0;
      else if (head_from_tail) head_p1 <= tail_p1;
      if (load_tail)           tail_p1 <= entry_p0;
    end
  end

  assign taken   = head_p1.taken;
  assign illegal = head_p1.illegal;
  assign next_pc = head_p1.next_pc;

`ifdef BRANCH_STATS_EN
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == {CNTW{1'b1}}) ? v : v + {{(CNTW-1){1'b0}}, 1'b1};
  endfunction

  // A flush cancels the pop of that cycle, so nothing is counted then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count    <= '0;
      taken_count <= '0;
    end else if (pop && !flush) begin
      br_count <= sat_inc(br_count);
      if (head_p1.taken) taken_count <= sat_inc(taken_count);
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;
  localparam int XLEN = 64;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic            eq, lt, ltu;
  logic [XLEN-1:0] pc, imm;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            taken;
  logic [XLEN-1:0] next_pc;
  logic            illegal;
`ifdef BRANCH_STATS_EN
  logic [CNTW-1:0] br_count, taken_count;
`endif

  branch_resolve #(.XLEN(XLEN), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .eq(eq), .lt(lt), .ltu(ltu), .pc(pc), .imm(imm),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .taken(taken), .next_pc(next_pc), .illegal(illegal)
`ifdef BRANCH_STATS_EN
    , .br_count(br_count), .taken_count(taken_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          tk;
    bit          il;
    logic [63:0] npc;
  } exp_t;

  exp_t exp_q[$];
  int   m_br, m_tk;
  int   n_vec, n_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: condition table indexed by funct3, then target add.
  function automatic exp_t model_entry(input bit [2:0] f3, input bit e, input bit l,
                                       input bit lu, input logic [63:0] p,
                                       input logic [63:0] im);
    exp_t r;
    bit   cond[8];
    cond = '{e, !e, 1'b0, 1'b0, l, !l, lu, !lu};
    r.tk  = cond[f3];
    r.il  = (f3 == 3'd2) || (f3 == 3'd3);
    r.npc = r.tk ? p + im : p + 64'd4;
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v >= (1 << CNTW) - 1) ? v : v + 1;
  endfunction

  task automatic check_outputs();
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("in_ready", in_ready, exp_q.size() < 2);
    if (exp_q.size() != 0) begin
      chk("taken", taken, exp_q[0].tk);
      chk("illegal", illegal, exp_q[0].il);
      chk("next_pc", next_pc, exp_q[0].npc);
    end
`ifdef BRANCH_STATS_EN
    chk("br_count", br_count, m_br);
    chk("taken_count", taken_count, m_tk);
`endif
  endtask

  // Called at a negedge: checks outputs, drives one cycle of inputs, advances
  // the reference across the rising edge and returns at the next negedge.
  task automatic step(input bit iv, input bit [2:0] f3, input bit e, input bit l,
                      input bit lu, input logic [63:0] p, input logic [63:0] im,
                      input bit fl, input bit ordy);
    bit do_push, do_pop;
    exp_t ne;
    check_outputs();
    in_valid = iv; funct3 = f3; eq = e; lt = l; ltu = lu;
    pc = p; imm = im; flush = fl; out_ready = ordy;
    do_push = iv && (exp_q.size() < 2);
    do_pop  = ordy && (exp_q.size() != 0);
    ne = model_entry(f3, e, l, lu, p, im);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (do_pop) begin
        m_br = sat(m_br);
        if (exp_q[0].tk) m_tk = sat(m_tk);
        void'(exp_q.pop_front());
      end
      if (do_push) exp_q.push_back(ne);
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, ordy);
  endtask

  initial begin
    logic [63:0] rp, ri;
    bit [2:0]    rf;
    n_vec = 0; n_err = 0; m_br = 0; m_tk = 0;
    rst_n = 1'b0; in_valid = 1'b0; funct3 = 3'd0; eq = 1'b0; lt = 1'b0; ltu = 1'b0;
    pc = '0; imm = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_taken", taken, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_next_pc", next_pc, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // BEQ taken
    step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 64'h1000, 64'h20, 1'b0, 1'b1);
    chk("beq_valid", out_valid, 1'b1);
    chk("beq_taken", taken, 1'b1);
    chk("beq_npc", next_pc, 64'h1020);
    idle(1'b1);

    // BGEU not taken, pc+4 wraps to zero
    step(1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 1'b0, 1'b1);
    chk("bgeu_taken", taken, 1'b0);
    chk("bgeu_npc", next_pc, 64'h0);
    idle(1'b1);

    // Illegal code
    step(1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 64'h2000, 64'h100, 1'b0, 1'b1);
    chk("ill_flag", illegal, 1'b1);
    chk("ill_taken", taken, 1'b0);
    chk("ill_npc", next_pc, 64'h2004);
    idle(1'b1);

    // Backpressure: three pushes, only two accepted, then drain in order
    step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 64'h3000, 64'h10, 1'b0, 1'b0);
    step(1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 64'h4000, 64'h10, 1'b0, 1'b0);
    chk("bp_in_ready", in_ready, 1'b0);
    step(1'b1, 3'b100, 1'b0, 1'b1, 1'b0, 64'h5000, 64'h10, 1'b0, 1'b0);
    chk("bp_hold_npc", next_pc, 64'h3010);
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    chk("bp_second_npc", next_pc, 64'h4004);
    idle(1'b1);
    chk("bp_drained", out_valid, 1'b0);

    // Flush while FULL with a simultaneous push
    step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 64'h6000, 64'h8, 1'b0, 1'b0);
    step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 64'h7000, 64'h8, 1'b0, 1'b0);
    step(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 64'h8000, 64'h8, 1'b1, 1'b1);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    idle(1'b1);

    // Asynchronous reset while FULL, checked before any clock edge
    step(1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 64'h9000, 64'h30, 1'b0, 1'b0);
    step(1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 64'hA000, 64'h30, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_taken", taken, 1'b0);
    chk("arst_npc", next_pc, 64'h0);
    exp_q.delete(); m_br = 0; m_tk = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rf = 3'($urandom_range(0, 7));
      rp = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ri = {$urandom, $urandom};
      else begin
        ri = 64'($urandom_range(0, 8191));
        ri = {{51{ri[12]}}, ri[12:0]};
      end
      step($urandom_range(0, 9) < 7, rf, 1'($urandom), 1'($urandom), 1'($urandom),
           rp, ri, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    end
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
